// File: rtl/stopwatch_mode_ctrl_if.sv
// Button/flag inputs and control outputs between the debouncers, the mode
// sequencer and the MM:SS datapath.
interface stopwatch_mode_ctrl_if;
    logic       btn_c;
    logic       btn_u;
    logic       btn_d;
    logic       btn_l;
    logic       btn_r;
    logic       cnt_zero;
    logic       cnt_max;
    logic       set_mode;
    logic       ed_up;
    logic       ed_down;
    logic       ed_left;
    logic       ed_right;
    logic       run_dir;
    logic       tick;
    logic       clear;
    logic       expired;
    logic [2:0] state;

    modport master (
        output btn_c, btn_u, btn_d, btn_l, btn_r, cnt_zero, cnt_max,
        input  set_mode, ed_up, ed_down, ed_left, ed_right, run_dir, tick, clear, expired, state
    );

    modport slave (
        input  btn_c, btn_u, btn_d, btn_l, btn_r, cnt_zero, cnt_max,
        output set_mode, ed_up, ed_down, ed_left, ed_right, run_dir, tick, clear, expired, state
    );
endinterface

// File: rtl/stopwatch_mode_ctrl.sv
// Mode sequencer for the MM:SS stopwatch: IDLE/SET/RUN/PAUSE/EXPIRED, the
// count-tick prescaler and the SET inactivity timeout. Every output is a flop.
module stopwatch_mode_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 1,
    parameter int SET_TIMEOUT_S = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_mode_ctrl_if.slave sw
);
    localparam int P  = CLK_HZ / TICK_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int TW = $clog2(SET_TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        SET     = 3'b001,
        RUN     = 3'b010,
        PAUSE   = 3'b011,
        EXPIRED = 3'b100
    } state_t;

    state_t          st;
    logic [PW-1:0]   pre;
    logic [TW-1:0]   tmo;
    logic            set_mode_q, ed_up_q, ed_down_q, ed_left_q, ed_right_q;
    logic            run_dir_q, tick_q, clear_q, expired_q;

    logic            b_c, b_u, b_d, b_l, b_r, any_btn;
    logic            wrap;
    logic [PW-1:0]   pre_nxt;

    // Priority resolve: only the highest-priority button of a cycle survives.
    always_comb begin
        b_c     = sw.btn_c;
        b_u     = sw.btn_u & ~sw.btn_c;
        b_d     = sw.btn_d & ~sw.btn_c & ~sw.btn_u;
        b_l     = sw.btn_l & ~sw.btn_c & ~sw.btn_u & ~sw.btn_d;
        b_r     = sw.btn_r & ~sw.btn_c & ~sw.btn_u & ~sw.btn_d & ~sw.btn_l;
        any_btn = sw.btn_c | sw.btn_u | sw.btn_d | sw.btn_l | sw.btn_r;
        wrap    = (pre == PW'(P - 1));
        pre_nxt = wrap ? '0 : pre + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            pre        <= '0;
            tmo        <= '0;
            set_mode_q <= 1'b0;
            ed_up_q    <= 1'b0;
            ed_down_q  <= 1'b0;
            ed_left_q  <= 1'b0;
            ed_right_q <= 1'b0;
            run_dir_q  <= 1'b1;
            tick_q     <= 1'b0;
            clear_q    <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            ed_up_q    <= 1'b0;
            ed_down_q  <= 1'b0;
            ed_left_q  <= 1'b0;
            ed_right_q <= 1'b0;
            tick_q     <= 1'b0;
            clear_q    <= 1'b0;
            case (st)
                IDLE: begin
                    if (b_c) begin
                        st         <= SET;
                        set_mode_q <= 1'b1;
                        pre        <= '0;
                        tmo        <= '0;
                    end else if (b_u) begin
                        st        <= RUN;
                        run_dir_q <= 1'b1;
                        pre       <= '0;
                    end else if (b_d && !sw.cnt_zero) begin
                        st        <= RUN;
                        run_dir_q <= 1'b0;
                        pre       <= '0;
                    end else if (b_l) begin
                        clear_q <= 1'b1;
                    end
                end
                SET: begin
                    pre <= pre_nxt;
                    if (b_c) begin
                        st         <= IDLE;
                        set_mode_q <= 1'b0;
                    end else begin
                        ed_up_q    <= b_u;
                        ed_down_q  <= b_d;
                        ed_left_q  <= b_l;
                        ed_right_q <= b_r;
                        if (any_btn) begin
                            tmo <= '0;
                        end else if (wrap) begin
                            if (tmo == TW'(SET_TIMEOUT_S - 1)) begin
                                st         <= IDLE;
                                set_mode_q <= 1'b0;
                            end else begin
                                tmo <= tmo + 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    // Limit exits beat the tick; the centre button beats both.
                    pre <= pre_nxt;
                    if (b_c) begin
                        st <= PAUSE;
                    end else if (!run_dir_q && sw.cnt_zero) begin
                        st        <= EXPIRED;
                        expired_q <= 1'b1;
                    end else if (run_dir_q && sw.cnt_max) begin
                        st <= PAUSE;
                    end else begin
                        tick_q <= wrap;
                    end
                end
                PAUSE: begin
                    if (b_c) begin
                        st <= RUN;
                    end else if (b_d) begin
                        st      <= IDLE;
                        clear_q <= 1'b1;
                    end
                end
                EXPIRED: begin
                    if (any_btn) begin
                        st        <= IDLE;
                        expired_q <= 1'b0;
                    end
                end
                default: begin
                    st         <= IDLE;
                    set_mode_q <= 1'b0;
                    expired_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sw.state    = st;
    assign sw.set_mode = set_mode_q;
    assign sw.ed_up    = ed_up_q;
    assign sw.ed_down  = ed_down_q;
    assign sw.ed_left  = ed_left_q;
    assign sw.ed_right = ed_right_q;
    assign sw.run_dir  = run_dir_q;
    assign sw.tick     = tick_q;
    assign sw.clear    = clear_q;
    assign sw.expired  = expired_q;
endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Bench for stopwatch_mode_ctrl: directed scenarios with literal expectations
// plus random button/flag traffic checked every cycle against a reference model.
module tb_stopwatch_mode_ctrl;
    localparam int P   = 10;
    localparam int TMO = 3;
    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    stopwatch_mode_ctrl_if bus();

    stopwatch_mode_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .SET_TIMEOUT_S(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .sw (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_run counts prescaled cycles since the last zero point; a tick boundary
    // is every P-th such cycle. m_quiet counts boundaries without a button in SET.
    int  m_st = M_IDLE;
    bit  m_dir = 1'b1;
    int  m_run = 0;
    int  m_quiet = 0;
    bit  e_up, e_dn, e_l, e_r, e_tick, e_clr;
    int  win;
    bit  bnd;
    logic [4:0] btns;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = M_IDLE; m_dir = 1'b1; m_run = 0; m_quiet = 0;
            {e_up, e_dn, e_l, e_r, e_tick, e_clr} = '0;
        end else begin
            btns = {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r};
            win = 5;
            for (int i = 4; i >= 0; i--) if (btns[i] && win == 5) win = 4 - i;
            {e_up, e_dn, e_l, e_r, e_tick, e_clr} = '0;
            bnd = ((m_run + 1) % P) == 0;
            case (m_st)
                M_IDLE: begin
                    if (win == 0) begin m_st = M_SET; m_run = 0; m_quiet = 0; end
                    else if (win == 1) begin m_st = M_RUN; m_dir = 1; m_run = 0; end
                    else if (win == 2 && !bus.cnt_zero) begin m_st = M_RUN; m_dir = 0; m_run = 0; end
                    else if (win == 3) e_clr = 1;
                end
                M_SET: begin
                    m_run++;
                    if (win == 0) m_st = M_IDLE;
                    else begin
                        e_up = (win == 1); e_dn = (win == 2); e_l = (win == 3); e_r = (win == 4);
                        if (win != 5) m_quiet = 0;
                        else if (bnd) m_quiet++;
                        if (m_quiet == TMO) m_st = M_IDLE;
                    end
                end
                M_RUN: begin
                    m_run++;
                    if (win == 0) m_st = M_PAUSE;
                    else if (!m_dir && bus.cnt_zero) m_st = M_EXP;
                    else if (m_dir && bus.cnt_max) m_st = M_PAUSE;
                    else e_tick = bnd;
                end
                M_PAUSE: begin
                    if (win == 0) m_st = M_RUN;
                    else if (win == 2) begin m_st = M_IDLE; e_clr = 1; end
                end
                default: if (win != 5) m_st = M_IDLE;
            endcase
        end
    end

    function automatic int dut_vec();
        return {bus.state, bus.set_mode, bus.ed_up, bus.ed_down, bus.ed_left,
                bus.ed_right, bus.run_dir, bus.tick, bus.clear, bus.expired};
    endfunction

    function automatic int model_vec();
        logic [2:0] s = 3'(m_st);
        return {s, m_st == M_SET, e_up, e_dn, e_l, e_r, m_dir, e_tick, e_clr, m_st == M_EXP};
    endfunction

    always @(negedge clk) if (!rst) check("outputs_vs_model", dut_vec(), model_vec());

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic [4:0] b);  // {c,u,d,l,r}
        {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = b;
        step(1);
        {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = '0;
    endtask

    localparam logic [4:0] BC = 5'b10000, BU = 5'b01000, BD = 5'b00100, BL = 5'b00010, BR = 5'b00001;

    int nt, k;

    initial begin
        {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = '0;
        bus.cnt_zero = 1'b0;
        bus.cnt_max  = 1'b0;
        step(3);
        check("reset_state", bus.state, 0);
        check("reset_run_dir", bus.run_dir, 1);
        check("reset_outputs", {bus.set_mode, bus.tick, bus.clear, bus.expired}, 0);
        rst = 1'b0;

        // run up: 5 ticks in 50 cycles
        pulse(BU);
        check("up_state", bus.state, 2);
        check("up_run_dir", bus.run_dir, 1);
        nt = 0;
        for (int i = 0; i < 50; i++) begin step(1); if (bus.tick) nt++; end
        check("ticks_in_50", nt, 5);
        check("tick_on_50th", bus.tick, 1);

        // pause 37 cycles, resume from the held prescaler
        pulse(BC);
        check("pause_state", bus.state, 3);
        nt = 0;
        for (int i = 0; i < 37; i++) begin step(1); if (bus.tick) nt++; end
        check("pause_no_tick", nt, 0);
        pulse(BC);
        check("resume_state", bus.state, 2);
        k = 0;
        do begin step(1); k++; end while (!bus.tick && k < 20);
        check("resume_tick_delay", k, 9);

        // pause then down: clear and back to idle
        pulse(BC);
        pulse(BD);
        check("pause_d_clear", bus.clear, 1);
        check("pause_d_state", bus.state, 0);
        step(1);
        check("clear_one_cycle", bus.clear, 0);

        // set mode edits and inactivity timeout
        pulse(BC);
        check("set_state", bus.state, 1);
        check("set_mode", bus.set_mode, 1);
        pulse(BU);
        check("set_ed_up", {bus.ed_up, bus.ed_down, bus.ed_left, bus.ed_right}, 4'b1000);
        pulse(BL);
        check("set_ed_left", {bus.ed_up, bus.ed_down, bus.ed_left, bus.ed_right}, 4'b0010);
        k = 2;
        do begin step(1); k++; end while (bus.state != 0 && k < 80);
        check("set_timeout_cycles", k, 30);
        check("set_mode_off", bus.set_mode, 0);

        // countdown blocked at zero, then expiry
        bus.cnt_zero = 1'b1;
        pulse(BD);
        check("down_at_zero_ignored", bus.state, 0);
        bus.cnt_zero = 1'b0;
        pulse(BD);
        check("down_state", bus.state, 2);
        check("down_run_dir", bus.run_dir, 0);
        step(3);
        bus.cnt_zero = 1'b1;
        step(1);
        check("expired_state", bus.state, 4);
        check("expired_flag", bus.expired, 1);
        bus.cnt_zero = 1'b0;
        pulse(BR);
        check("expired_exit", {bus.state, bus.expired, bus.ed_right}, 0);

        // priority: c beats u in idle
        pulse(BC | BU);
        check("prio_c_over_u", {bus.state, bus.ed_up}, {3'd1, 1'b0});
        pulse(BC);

        // count-up saturation at 59:59
        pulse(BU);
        step(2);
        bus.cnt_max = 1'b1;
        step(1);
        check("max_pause", {bus.state, bus.tick}, {3'd3, 1'b0});
        bus.cnt_max = 1'b0;
        pulse(BD);

        // asynchronous reset mid-run, right after a tick
        pulse(BD);
        k = 0;
        while (!bus.tick && k < 20) begin step(1); k++; end
        check("tick_before_reset", bus.tick, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", bus.state, 0);
        check("async_rst_tick", bus.tick, 0);
        check("async_rst_run_dir", bus.run_dir, 1);
        @(posedge clk); #1 rst = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = 5'($urandom_range(1, 31));
            else
                {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = '0;
            bus.cnt_zero = ($urandom_range(0, 15) == 0);
            bus.cnt_max  = ($urandom_range(0, 15) == 0);
            step(1);
        end
        {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r} = '0;
        bus.cnt_zero = 1'b0;
        bus.cnt_max  = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
